issue_ctrl: RTL
===============

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter MULDIV_LAT, default 4, meaning cycles a mul/div occupies EX before the next issue is allowed (legal range 1..15).
REQ-002 Parameter CNT_W, default 16, meaning width of the stall performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  decoded instruction present in ID.
REQ-006 id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register addresses from the decoder.
REQ-007 id_rs1_used, id_rs2_used  in  1 each  instruction reads rs1 / rs2.
REQ-008 id_wb_en  in  1  instruction writes rd.
REQ-009 id_is_muldiv  in  1  instruction is a multi-cycle mul/div.
REQ-010 wb_valid  in  1, wb_rd  in  5  register-file write occurring this cycle.
REQ-011 ex_flush  in  1  branch/jump taken in EX; kill the ID instruction.
REQ-012 issue  out  1  ID instruction advances to EX this cycle.
REQ-013 stall_if, stall_id  out  1 each  hold PC / IF-ID register.
REQ-014 flush_id  out  1  insert bubble into ID/EX.
REQ-015 busy_vec  out  32  scoreboard, bit n = write to xn pending.
REQ-016 stall_cnt  out  CNT_W  count of stalled cycles.

Function
REQ-017 States: RUN, MD_WAIT; 4-bit down-counter md_cnt.
REQ-018 clr_mask = one-hot(wb_rd) when wb_valid and wb_rd != 0, else 0; eff_busy = busy_vec & ~clr_mask (same-cycle writeback resolves hazard).
REQ-019 hazard = id_valid AND (rs1 RAW: id_rs1_used, rs1!=0, eff_busy[rs1]) OR (rs2 RAW likewise) OR (WAW: id_wb_en, rd!=0, eff_busy[rd]).
REQ-020 x0 never sets or checks busy; busy_vec[0] always 0.
REQ-021 issue = id_valid AND NOT hazard AND state==RUN AND NOT ex_flush AND NOT rst (combinational, zero latency).
REQ-022 flush_id = ex_flush OR (id_valid AND NOT issue).
REQ-023 stall_if = stall_id = id_valid AND NOT issue AND NOT ex_flush.
REQ-024 On issue with id_wb_en and rd!=0: busy_vec[rd] set next cycle.
REQ-025 Busy bits in clr_mask cleared next cycle; simultaneous set and clear of same bit -> set wins.
REQ-026 RUN -> MD_WAIT when issue AND id_is_muldiv; md_cnt loaded MULDIV_LAT-1; if MULDIV_LAT==1 stay RUN.
REQ-027 MD_WAIT: md_cnt decrements each cycle; at md_cnt==1 -> RUN next cycle (exactly MULDIV_LAT-1 cycles of blocked issue after the muldiv issue cycle).
REQ-028 ex_flush does not abort MD_WAIT or clear busy bits (muldiv and issued instructions are older than the branch).
REQ-029 stall_cnt increments when stall_id=1; saturates at all-ones, never wraps.
REQ-030 Reset mid-operation (any state, any busy pattern) returns to reset values next edge; issue forced 0 while rst=1.

Reset
REQ-031 On rst: state=RUN, md_cnt=0, busy_vec=0, stall_cnt=0.
REQ-032 Post-reset with id_valid=0: issue=0, stall_if=stall_id=0, flush_id=ex_flush.

Verification
REQ-033 RAW: issue rd=x5 wb_en; next cycle id rs1=x5 -> issue=0, stall_id=1, busy_vec[5]=1; wb_valid wb_rd=5 that cycle -> issue=1 same cycle, busy_vec[5]=0 next.
REQ-034 x0: id rd=0 wb_en issue, then rs1=0 -> busy_vec stays 0, no stall.
REQ-035 MULDIV_LAT=4: issue muldiv at cycle t -> issue=0 at t+1..t+3 with id_valid=1 and no hazard, issue=1 at t+4; stall_cnt=3.
REQ-036 Flush: id_valid=1, hazard=0, ex_flush=1 -> issue=0, flush_id=1, stall_if=0, no busy bit set.
REQ-037 Set/clear collision: issue rd=x7 while wb_valid wb_rd=7 with busy[7]=1 -> busy_vec[7]=1 next cycle.
REQ-038 Reset in MD_WAIT with busy_vec=0x0000_00A0, stall_cnt=9 -> next cycle state RUN, busy_vec=0, stall_cnt=0, issue allowed once rst=0.

Source files
------------

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue control for the ID stage.
//
// Decides each cycle whether the instruction in ID may advance to EX. Issue is
// blocked by register hazards (RAW on rs1/rs2, WAW on rd) tracked in a 32-entry
// busy scoreboard, and by a multi-cycle mul/div still occupying EX.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 decoded instruction present in ID
//   id_rs1_addr/id_rs2_addr  source register addresses
//   id_rd_addr               destination register address
//   id_rs1_used/id_rs2_used  instruction reads rs1 / rs2
//   id_wb_en                 instruction writes rd
//   id_is_muldiv             instruction is a multi-cycle mul/div
//   wb_valid, wb_rd          register-file write happening this cycle
//   ex_flush                 taken branch/jump in EX, kill the ID instruction
//   issue                    ID instruction advances to EX this cycle
//   stall_if, stall_id       hold PC / IF-ID register
//   flush_id                 insert bubble into ID/EX
//   busy_vec                 scoreboard, bit n = write to xn pending
//   stall_cnt                saturating count of stalled cycles
module issue_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_wb_en,
  input  logic             id_is_muldiv,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             ex_flush,
  output logic             issue,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_LAT - 1);

  state_t      state, state_nxt;
  logic [3:0]  md_cnt, md_cnt_nxt;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] eff_busy;
  logic        rs1_raw, rs2_raw, rd_waw, hazard;

  // A writeback landing this cycle already resolves the hazard on its register,
  // so the consumer may issue in the same cycle.
  always_comb begin
    clr_mask = '0;
    if (wb_valid && (wb_rd != 5'd0)) clr_mask[wb_rd] = 1'b1;
    eff_busy = busy_vec & ~clr_mask;

    rs1_raw = id_rs1_used && (id_rs1_addr != 5'd0) && eff_busy[id_rs1_addr];
    rs2_raw = id_rs2_used && (id_rs2_addr != 5'd0) && eff_busy[id_rs2_addr];
    rd_waw  = id_wb_en    && (id_rd_addr  != 5'd0) && eff_busy[id_rd_addr];
    hazard  = id_valid && (rs1_raw || rs2_raw || rd_waw);

    issue    = id_valid && !hazard && (state == RUN) && !ex_flush && !rst;
    flush_id = ex_flush || (id_valid && !issue);
    stall_id = id_valid && !issue && !ex_flush;
    stall_if = stall_id;

    set_mask = '0;
    if (issue && id_wb_en && (id_rd_addr != 5'd0)) set_mask[id_rd_addr] = 1'b1;
  end

  // Mul/div occupancy: after the issuing cycle, md_cnt counts the remaining
  // blocked cycles down to 1, then issue reopens.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      RUN: begin
        if (issue && id_is_muldiv && (MULDIV_LAT > 1)) begin
          state_nxt  = MD_WAIT;
          md_cnt_nxt = MD_LOAD;
        end
      end
      MD_WAIT: begin
        md_cnt_nxt = md_cnt - 4'd1;
        if (md_cnt == 4'd1) state_nxt = RUN;
      end
      default: begin
        state_nxt  = RUN;
        md_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      md_cnt    <= '0;
      busy_vec  <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      md_cnt    <= md_cnt_nxt;
      // Set is applied after clear so a same-cycle set of the same bit wins;
      // x0 is never tracked.
      busy_vec  <= ((busy_vec & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
      if (stall_id && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
